// File: rtl/audio_note_sequencer.sv
// audio_note_sequencer
//   Queues note requests (valid/ready) in a small FIFO and plays them in order
//   on the audio PMOD as a PWM square wave. Each note lasts req_dur ticks and
//   is followed by a fixed silent gap. Octave is chosen per note; duty is live.
//
// Ports
//   clk, reset_n      system clock, synchronous active-low reset
//   enable            play enable; low freezes playback and silences output
//   flush             drops the queue and the current note
//   req_valid/ready   note request handshake
//   req_note          0..11 = C..B, 12..15 = rest
//   req_octave        octave shift up (period >> octave)
//   req_dur           note length in ticks
//   duty              PWM duty, fraction of 2**DUTY_W
//   pmod_1            AIN, registered PWM output
//   pmod_2            GAIN, tied to GAIN_HI
//   pmod_4            SHUTDOWN_N, registered (enable && playing/gapping)
//   busy              note/gap in progress or queue non-empty
//   fifo_count        number of queued requests
module audio_note_sequencer #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEPTH       = 8,
  parameter int DUR_W       = 8,
  parameter int OCT_W       = 2,
  parameter int DUTY_W      = 8,
  parameter int TICK_CYCLES = 100_000,
  parameter int GAP_TICKS   = 10,
  parameter bit GAIN_HI     = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_note,
  input  logic [OCT_W-1:0]       req_octave,
  input  logic [DUR_W-1:0]       req_dur,
  input  logic [DUTY_W-1:0]      duty,
  output logic                   pmod_1,
  output logic                   pmod_2,
  output logic                   pmod_4,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int PER_W   = $clog2(CLK_HZ / 262 + 1);  // lowest note has the longest period
  localparam int PW      = PER_W + DUTY_W;
  localparam int TICK_W  = $clog2(TICK_CYCLES + 1);
  localparam int GAP_CYC = GAP_TICKS * TICK_CYCLES;
  localparam int GAP_W   = $clog2(GAP_CYC + 2);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [AW:0]       FULL_CNT  = (AW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  // State entered when a note ends; the gap is skipped entirely when zero-length.
  localparam logic [1:0] S_AFTER = (GAP_CYC > 0) ? S_GAP : S_IDLE;

  typedef struct packed {
    logic [3:0]       note;
    logic [OCT_W-1:0] oct;
    logic [DUR_W-1:0] dur;
  } req_t;

  // Clock cycles per wave period for each semitone of the base octave.
  function automatic logic [PER_W-1:0] rom_period(input logic [3:0] n);
    case (n)
      4'd0:    rom_period = PER_W'(CLK_HZ / 262);
      4'd1:    rom_period = PER_W'(CLK_HZ / 277);
      4'd2:    rom_period = PER_W'(CLK_HZ / 294);
      4'd3:    rom_period = PER_W'(CLK_HZ / 311);
      4'd4:    rom_period = PER_W'(CLK_HZ / 330);
      4'd5:    rom_period = PER_W'(CLK_HZ / 349);
      4'd6:    rom_period = PER_W'(CLK_HZ / 370);
      4'd7:    rom_period = PER_W'(CLK_HZ / 392);
      4'd8:    rom_period = PER_W'(CLK_HZ / 415);
      4'd9:    rom_period = PER_W'(CLK_HZ / 440);
      4'd10:   rom_period = PER_W'(CLK_HZ / 466);
      4'd11:   rom_period = PER_W'(CLK_HZ / 494);
      default: rom_period = PER_W'(CLK_HZ / 262);  // rests: any valid period, output forced low
    endcase
  endfunction

  // ---------------- FIFO ----------------
  req_t            r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic [1:0]      r_state;
  logic            w_empty, w_push, w_pop;
  req_t            w_head;

  assign w_empty   = (r_count == '0);
  assign req_ready = (r_count != FULL_CNT) && !flush;
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == S_IDLE) && enable && !flush && !w_empty;
  assign w_head    = r_mem[r_rd_ptr];

  // NOTE: storage array has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{note: req_note, oct: req_octave, dur: req_dur};
  end

  // NOTE: all state is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- Player ----------------
  logic [3:0]        r_note;
  logic [PER_W-1:0]  r_period, r_phase;
  logic [TICK_W-1:0] r_tick;
  logic [DUR_W-1:0]  r_dur_left;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_pmod1, r_pmod4;
  logic [PW-1:0]     w_prod;
  logic [PER_W-1:0]  w_high, w_head_period;
  logic              w_tone_hi;

  assign w_head_period = rom_period(w_head.note) >> w_head.oct;
  // Full-width product; high time never exceeds the period so the top slice fits.
  assign w_prod    = PW'(r_period) * PW'(duty);
  assign w_high    = w_prod[PW-1:DUTY_W];
  assign w_tone_hi = (r_note < 4'd12) && (r_phase < w_high);

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_state    <= S_IDLE;
      r_note     <= '0;
      r_period   <= '0;
      r_phase    <= '0;
      r_tick     <= '0;
      r_dur_left <= '0;
      r_gap_cnt  <= '0;
      r_pmod1    <= 1'b0;
    end else if (!enable) begin
      r_pmod1 <= 1'b0;  // pause: everything else holds
    end else begin
      r_pmod1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_note     <= w_head.note;
            r_period   <= w_head_period;
            r_phase    <= '0;
            r_tick     <= '0;
            r_dur_left <= w_head.dur;
            r_gap_cnt  <= '0;
            r_state    <= (w_head.dur == '0) ? S_AFTER : S_PLAY;
          end
        end
        S_PLAY: begin
          r_phase <= (r_phase == r_period - PER_W'(1)) ? '0 : r_phase + PER_W'(1);
          if (r_tick == TICK_LAST) begin
            r_tick     <= '0;
            r_dur_left <= r_dur_left - DUR_W'(1);
            if (r_dur_left == DUR_W'(1)) begin
              r_gap_cnt <= '0;
              r_state   <= S_AFTER;  // last edge of the note drives the output low
            end else begin
              r_pmod1 <= w_tone_hi;
            end
          end else begin
            r_tick  <= r_tick + TICK_W'(1);
            r_pmod1 <= w_tone_hi;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_pmod4 <= 1'b0;
    else          r_pmod4 <= enable && (r_state != S_IDLE);
  end

  assign pmod_1     = r_pmod1;
  assign pmod_2     = GAIN_HI;
  assign pmod_4     = r_pmod4;
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Self-checking bench for audio_note_sequencer. Expected waveforms come from a
// frequency-table model: enabled play cycle j of a note is high when the note
// is a tone, j is not the final cycle of the note, and (j mod period) < high.
module tb_audio_note_sequencer;

  localparam int CLK_HZ      = 1_000_000;
  localparam int DEPTH       = 8;
  localparam int DUR_W       = 8;
  localparam int OCT_W       = 2;
  localparam int DUTY_W      = 8;
  localparam int TICK_CYCLES = 100;
  localparam int GAP_TICKS   = 2;
  localparam int GAP_CYC     = GAP_TICKS * TICK_CYCLES;
  localparam int FREQ [12]   = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};

  logic                   clk = 1'b0;
  logic                   reset_n, enable, flush, req_valid, req_ready;
  logic [3:0]             req_note;
  logic [OCT_W-1:0]       req_octave;
  logic [DUR_W-1:0]       req_dur;
  logic [DUTY_W-1:0]      duty;
  logic                   pmod_1, pmod_2, pmod_4, busy;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;

  audio_note_sequencer #(
    .CLK_HZ(CLK_HZ), .DEPTH(DEPTH), .DUR_W(DUR_W), .OCT_W(OCT_W), .DUTY_W(DUTY_W),
    .TICK_CYCLES(TICK_CYCLES), .GAP_TICKS(GAP_TICKS), .GAIN_HI(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_note(req_note),
    .req_octave(req_octave), .req_dur(req_dur), .duty(duty),
    .pmod_1(pmod_1), .pmod_2(pmod_2), .pmod_4(pmod_4), .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_level(input int note, input int oct, input int dur,
                                     input int dty, input int j);
    int p, hi;
    if (note >= 12) return 1'b0;
    p  = (CLK_HZ / FREQ[note]) >> oct;
    hi = (p * dty) >> DUTY_W;
    if (j >= dur * TICK_CYCLES - 1) return 1'b0;
    return (j % p) < hi;
  endfunction

  task automatic set_req(input int note, input int oct, input int dur);
    req_note   = 4'(note);
    req_octave = OCT_W'(oct);
    req_dur    = DUR_W'(dur);
  endtask

  // Plays one note from an idle, empty, enabled block and checks the whole
  // waveform, an optional pause, the gap and the return to idle.
  task automatic play_note(input int note, input int oct, input int dur, input int dty,
                           input int pause_at, input int pause_len, input string name,
                           output int highs);
    int total, bad, first_bad, pause_bad, gap_bad;
    logic exp_v;
    total = dur * TICK_CYCLES;
    bad = 0; first_bad = -1; pause_bad = 0; gap_bad = 0; highs = 0;
    duty = DUTY_W'(dty);
    set_req(note, oct, dur);
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b expected 1", name, req_ready);
    end
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (pmod_1 !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s pop cycle: pmod_1=%b busy=%b expected 0/1", name, pmod_1, busy);
    end
    for (int j = 0; j < total; j++) begin
      if (j == pause_at) begin
        enable = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          step();
          if (pmod_1 !== 1'b0 || pmod_4 !== 1'b0) pause_bad++;
        end
        enable = 1'b1;
      end
      step();
      exp_v = ref_level(note, oct, dur, dty, j);
      if (pmod_1 !== exp_v) begin
        bad++;
        if (first_bad < 0) first_bad = j;
      end
      if (pmod_1 === 1'b1) highs++;
      if (j == 10) begin
        checks++;
        if (pmod_4 !== 1'b1) begin
          errors++;
          $display("FAIL %s pmod_4 playing: got %b expected 1", name, pmod_4);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s waveform: %0d wrong cycles, first at play cycle %0d, expected 0 wrong",
               name, bad, first_bad);
    end
    if (pause_len > 0) begin
      checks++;
      if (pause_bad != 0) begin
        errors++;
        $display("FAIL %s pause: %0d cycles with output active, expected 0", name, pause_bad);
      end
    end
    for (int g = 0; g < GAP_CYC - 1; g++) begin
      step();
      if (pmod_1 !== 1'b0 || busy !== 1'b1) gap_bad++;
    end
    checks++;
    if (gap_bad != 0) begin
      errors++;
      $display("FAIL %s gap: %0d bad cycles, expected 0", name, gap_bad);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle after gap: busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; flush = 1'b0; req_valid = 1'b0;
    set_req(0, 0, 0); duty = '0;
    repeat (3) step();
    checks++;
    if (pmod_1 !== 1'b0 || pmod_4 !== 1'b0 || busy !== 1'b0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL reset state: pmod_1=%b pmod_4=%b busy=%b count=%0d expected all 0",
               pmod_1, pmod_4, busy, fifo_count);
    end
    checks++;
    if (pmod_2 !== 1'b1) begin
      errors++;
      $display("FAIL gain pin: got %b expected 1", pmod_2);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_tone();
    int highs;
    // A4 two octaves up: period 568, high 284; 1199 driven cycles -> 2*284 + 63.
    play_note(9, 2, 12, 128, -1, 0, "tone", highs);
    checks++;
    if (highs != 631) begin
      errors++;
      $display("FAIL tone high count: got %0d expected 631", highs);
    end
  endtask

  task automatic test_fill();
    int accepts = 0;
    int active = 0;
    enable = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_req(i % 12, 0, 2);
      req_valid = 1'b1;
      if (req_ready === 1'b1) accepts++;
      step();
      if (pmod_1 !== 1'b0 || pmod_4 !== 1'b0) active++;
    end
    req_valid = 1'b0;
    checks++;
    if (accepts != DEPTH) begin
      errors++;
      $display("FAIL fill accepts: got %0d expected %0d", accepts, DEPTH);
    end
    checks++;
    if (fifo_count !== DEPTH || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill full: count=%0d ready=%b expected %0d/0", fifo_count, req_ready, DEPTH);
    end
    checks++;
    if (active != 0) begin
      errors++;
      $display("FAIL fill paused output: %0d active cycles expected 0", active);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (fifo_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fill cleanup: count=%0d busy=%b expected 0/0", fifo_count, busy);
    end
    enable = 1'b1;
    step();
  endtask

  task automatic test_pause();
    int highs;
    play_note(9, 2, 12, 128, 300, 500, "pause", highs);
    checks++;
    if (highs != 631) begin
      errors++;
      $display("FAIL pause high count: got %0d expected 631", highs);
    end
  endtask

  task automatic test_random();
    int highs, n, o, d, dt, exp_h;
    for (int i = 0; i < 6; i++) begin
      n  = $urandom_range(0, 15);
      o  = $urandom_range(0, 3);
      d  = $urandom_range(1, 3);
      dt = (i == 0) ? 0 : $urandom_range(0, 255);
      play_note(n, o, d, dt, -1, 0, "random", highs);
      exp_h = 0;
      for (int j = 0; j < d * TICK_CYCLES; j++) exp_h += int'(ref_level(n, o, d, dt, j));
      checks++;
      if (highs != exp_h) begin
        errors++;
        $display("FAIL random high count (note %0d oct %0d duty %0d): got %0d expected %0d",
                 n, o, dt, highs, exp_h);
      end
    end
  endtask

  task automatic test_rest_zero_dur();
    int busy_cycles = 0;
    int highs = 0;
    int budget = 0;
    duty = 8'd200;
    set_req(14, 1, 3);
    req_valid = 1'b1;
    step();
    if (busy === 1'b1) busy_cycles++;
    set_req(0, 0, 0);
    step();
    req_valid = 1'b0;
    if (busy === 1'b1) busy_cycles++;
    checks++;
    if (fifo_count !== 1) begin
      errors++;
      $display("FAIL rest push+pop count: got %0d expected 1", fifo_count);
    end
    while (busy === 1'b1 && budget < 2000) begin
      step();
      budget++;
      if (busy === 1'b1) busy_cycles++;
      if (pmod_1 === 1'b1) highs++;
    end
    checks++;
    if (budget >= 2000) begin
      errors++;
      $display("FAIL rest timeout: busy still %b after %0d cycles", busy, budget);
    end
    // 1 queued + 300 rest + 200 gap + 1 idle + 200 gap for the zero-length note.
    checks++;
    if (busy_cycles != 702) begin
      errors++;
      $display("FAIL rest busy length: got %0d expected 702", busy_cycles);
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL rest silence: got %0d high cycles expected 0", highs);
    end
  endtask

  task automatic test_flush();
    duty = 8'd255;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 0, 5);
      req_valid = 1'b1;
      step();
    end
    req_valid = 1'b0;
    repeat (50) step();
    checks++;
    if (fifo_count !== 3 || pmod_1 !== 1'b1) begin
      errors++;
      $display("FAIL flush setup: count=%0d pmod_1=%b expected 3/1", fifo_count, pmod_1);
    end
    flush = 1'b1;
    req_valid = 1'b1;
    set_req(5, 0, 4);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush ready: got %b expected 0", req_ready);
    end
    step();
    checks++;
    if (fifo_count !== '0 || pmod_1 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush result: count=%0d pmod_1=%b busy=%b expected 0/0/0",
               fifo_count, pmod_1, busy);
    end
    flush = 1'b0;
    req_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (fifo_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush dropped push: count=%0d busy=%b expected 0/0", fifo_count, busy);
    end
  endtask

  task automatic test_reset_mid_note();
    int highs;
    duty = 8'd128;
    set_req(9, 2, 12);
    req_valid = 1'b1;
    step();
    step();
    req_valid = 1'b0;
    repeat (100) step();
    checks++;
    if (busy !== 1'b1 || fifo_count !== 1) begin
      errors++;
      $display("FAIL reset setup: busy=%b count=%0d expected 1/1", busy, fifo_count);
    end
    reset_n = 1'b0;
    step();
    checks++;
    if (pmod_1 !== 1'b0 || pmod_4 !== 1'b0 || busy !== 1'b0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL reset mid-note: pmod_1=%b pmod_4=%b busy=%b count=%0d expected all 0",
               pmod_1, pmod_4, busy, fifo_count);
    end
    reset_n = 1'b1;
    step();
    play_note(9, 2, 12, 128, -1, 0, "after reset", highs);
    checks++;
    if (highs != 631) begin
      errors++;
      $display("FAIL after reset high count: got %0d expected 631", highs);
    end
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_fill();
    test_pause();
    test_random();
    test_rest_zero_dur();
    test_flush();
    test_reset_mid_note();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_note_sequencer.md
Name: audio_note_sequencer

Overview:
- Parametrised successor to the single-tone speaker driver.
- Accepts note requests over a valid/ready handshake and queues them in an internal FIFO.
- Plays each queued note in order for a programmed duration, as a square/PWM wave with run-time octave and duty, with a fixed silent gap between notes.
- Drives the PMOD amplifier pins directly. Sits between the game logic and the audio PMOD.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; used to build the note period ROM at elaboration.
- DEPTH, 8, FIFO entries (power of two, >=2).
- DUR_W, 8, width of the note duration field, in ticks.
- OCT_W, 2, width of the octave shift field.
- DUTY_W, 8, width of the duty field.
- TICK_CYCLES, 100_000, clock cycles per duration tick (1 ms at default).
- GAP_TICKS, 10, silent ticks inserted after each note; 0 means no gap.
- GAIN_HI, 1, constant driven on pmod_2.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- enable, in, 1, play enable (game running); low = pause.
- flush, in, 1, drop queue and current note.
- req_valid, in, 1, note request valid.
- req_ready, out, 1, request accepted when req_valid && req_ready at clk edge.
- req_note, in, 4, 0..11 = C..B semitone; 12..15 = rest.
- req_octave, in, OCT_W, octave shift up.
- req_dur, in, DUR_W, note length in ticks.
- duty, in, DUTY_W, PWM duty, sampled live.
- pmod_1, out, 1, AIN PWM output (registered).
- pmod_2, out, 1, GAIN = GAIN_HI.
- pmod_4, out, 1, SHUTDOWN_N.
- busy, out, 1, state != IDLE or FIFO non-empty.
- fifo_count, out, $clog2(DEPTH)+1, entries queued.

Behaviour:
- Reset (reset_n low at edge): FIFO empty, state IDLE, all counters 0, pmod_1=0, pmod_4=0, busy=0, fifo_count=0. Reset mid-note aborts the note with no residual output.
- Period ROM, indexed by note: CLK_HZ/f, integer-truncated, with f = 262,277,294,311,330,349,370,392,415,440,466,494 Hz.
  - period = ROM[note] >> octave.
  - high = (period*duty) >> DUTY_W, computed at full width without overflow.
- FIFO:
  - req_ready = !full && !flush.
  - Write on handshake. Pop only in IDLE when non-empty.
  - The FIFO is never written and popped in the same cycle while empty; push+pop while non-empty is legal and fifo_count is unchanged.
- FSM:
  - IDLE: if FIFO non-empty and enable, pop the entry. Load phase=0, tick=0, dur_left=req_dur, then go to PLAY. If req_dur==0, skip straight to GAP (or IDLE if GAP_TICKS==0).
  - PLAY: each cycle pmod_1 <= (note<12) && (phase < high). phase wraps to 0 at period-1. tick counts 0..TICK_CYCLES-1; at wrap, dur_left decrements. When dur_left reaches 0, go to GAP (or IDLE if GAP_TICKS==0) and set pmod_1 <= 0 on that edge.
  - GAP: pmod_1=0 for GAP_TICKS*TICK_CYCLES cycles, then go to IDLE.
- Latency: handshake at edge k into an empty idle block gives PLAY from edge k+2. For a tone, pmod_1 first goes high at edge k+2. Back-to-back notes are separated by exactly gap cycles plus 1 IDLE cycle.
- enable low: state and all counters freeze; pmod_1 <= 0. On enable returning high, play resumes from the frozen phase/tick. FIFO still accepts writes while paused.
- flush: at the edge, FIFO is cleared, state goes to IDLE and pmod_1 <= 0. Flush beats a simultaneous push (the push is dropped, since ready is low) and beats enable.
- pmod_4 = 1 iff enable && state != IDLE, registered.
- duty == 0 gives a silent tone.

Test Plan:
1. Setup: CLK_HZ=1_000_000, TICK_CYCLES=100, GAP_TICKS=2. Push note 9 (A), octave 2, dur 12, duty 128 -> period 568, pmod_1 high 284 / low 284 cycles, first rise at handshake+2. Exactly 1200 PLAY cycles, then 200 low cycles, then busy=0.
2. Fill: push DEPTH+1 requests back-to-back while paused (enable=0) -> req_ready drops after 8 accepts and fifo_count=8. pmod_1 stays 0.
3. Pause: mid-note, enable=0 for 500 cycles -> pmod_1=0 and pmod_4=0 during the pause. Remaining duration and waveform phase continue unchanged afterwards.
4. Rests and zero duration: push note 14 dur 3, then note 0 dur 0 -> 300 silent PLAY cycles. The dur-0 note produces no high cycles and only the gap.
5. Flush: flush asserted with 3 queued plus one playing, and req_valid=1 in the same cycle -> next edge fifo_count=0, pmod_1=0, state IDLE, request not accepted.
6. Reset: reset_n=0 mid-PLAY -> all outputs 0 next edge. After release, a new request behaves as in test 1.
